// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit indices and FSM encodings for the UART
package uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  localparam int ST_RX_FULL  = 0;
  localparam int ST_TX_READY = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FRAMING  = 3;
  localparam int ST_TX_BUSY  = 4;

  localparam int CTL_RX_IRQ_EN = 0;
  localparam int CTL_TX_IRQ_EN = 1;
  localparam int CTL_SOFT_RST  = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: input synchronizer, RX FSM and deserializer
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic rx_m, rx_s, rx_p;

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_d;
  logic [7:0]       byte_d;
  logic             ferr_d;

  // rx_p is one stage behind rx_s so a falling edge is visible as rx_p & ~rx_s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    byte_d  = rx_byte;
    ferr_d  = rx_frame_err;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_p && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          byte_d  = shreg_q;
          ferr_d  = ~rx_s;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_frame_err <= 1'b0;
    end else if (clr) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      rx_valid     <= valid_d;
      rx_byte      <= byte_d;
      rx_frame_err <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_regs.sv
// rtl/uart_regs.sv - memory-mapped UART: register file, TX FSM, RX instance and IRQ
module uart_regs
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_data_ce,
  input  logic       i_status_ce,
  input  logic       i_control_ce,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_irq
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic       acc, wr, rd;
  logic [1:0] sel;
  logic       data_wr, data_rd, status_rd, ctl_wr;

  logic [1:0] ctl;
  logic       soft_rst;
  logic [7:0] tx_hold, rx_hold;
  logic       tx_hold_full, rx_full, overrun, framing;
  logic [7:0] status_val;

  logic       rx_valid, rx_frame_err;
  logic [7:0] rx_byte;

  uart_state_t      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_take;
  logic             tx_busy;

  // Overlapping chip enables resolve as control > status > data
  always_comb begin
    acc = i_control_ce | i_status_ce | i_data_ce;
    if (i_control_ce)     sel = REG_CONTROL;
    else if (i_status_ce) sel = REG_STATUS;
    else                  sel = REG_DATA;
  end

  assign wr        = i_wr & acc;
  assign rd        = i_rd & acc;
  assign data_wr   = wr & (sel == REG_DATA);
  assign data_rd   = rd & (sel == REG_DATA);
  assign status_rd = rd & (sel == REG_STATUS);
  assign ctl_wr    = wr & (sel == REG_CONTROL);

  assign tx_busy = (tx_state_q != S_IDLE);

  always_comb begin
    status_val              = '0;
    status_val[ST_RX_FULL]  = rx_full;
    status_val[ST_TX_READY] = ~tx_hold_full;
    status_val[ST_OVERRUN]  = overrun;
    status_val[ST_FRAMING]  = framing;
    status_val[ST_TX_BUSY]  = tx_busy;
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_rx (
    .clk         (i_clk),
    .rst         (i_reset),
    .clr         (soft_rst),
    .rx          (i_rx),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_frame_err(rx_frame_err)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctl          <= '0;
      soft_rst     <= 1'b0;
      o_rdata      <= '0;
      tx_hold      <= '0;
      tx_hold_full <= 1'b0;
      rx_hold      <= '0;
      rx_full      <= 1'b0;
      overrun      <= 1'b0;
      framing      <= 1'b0;
      o_irq        <= 1'b0;
    end else begin
      soft_rst <= ctl_wr & i_wdata[CTL_SOFT_RST];
      if (ctl_wr) ctl <= i_wdata[1:0];

      if (rd) begin
        case (sel)
          REG_CONTROL: o_rdata <= {6'b0, ctl};
          REG_STATUS:  o_rdata <= status_val;
          default:     o_rdata <= rx_hold;
        endcase
      end

      if (soft_rst) begin
        tx_hold_full <= 1'b0;
        rx_full      <= 1'b0;
        overrun      <= 1'b0;
        framing      <= 1'b0;
        o_irq        <= 1'b0;
      end else begin
        if (tx_take) begin
          tx_hold_full <= 1'b0;
        end else if (data_wr && !tx_hold_full) begin
          tx_hold      <= i_wdata;
          tx_hold_full <= 1'b1;
        end

        // A data read in the delivery cycle frees the slot, so no overrun
        if (rx_valid) begin
          if (!(rx_full && !data_rd)) begin
            rx_hold <= rx_byte;
            rx_full <= 1'b1;
          end
        end else if (data_rd) begin
          rx_full <= 1'b0;
        end

        if (rx_valid && rx_full && !data_rd) overrun <= 1'b1;
        else if (status_rd)                  overrun <= 1'b0;

        if (rx_valid && rx_frame_err) framing <= 1'b1;
        else if (status_rd)           framing <= 1'b0;

        o_irq <= (ctl[CTL_RX_IRQ_EN] & rx_full) | (ctl[CTL_TX_IRQ_EN] & ~tx_hold_full);
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_take    = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (tx_hold_full) begin
          tx_take    = 1'b1;
          tx_shift_d = tx_hold;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (soft_rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Line is decoded straight from state so an async reset idles it at once
  always_comb begin
    case (tx_state_q)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = tx_shift_q[0];
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_regs.sv
// tb/tb_uart_regs.sv - directed self-checking bench for uart_regs
module tb_uart_regs;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_data_ce, i_status_ce, i_control_ce;
  logic       i_wr, i_rd;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;
  logic       i_rx;
  logic       o_tx;
  logic       o_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_regs #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_data_ce   (i_data_ce),
    .i_status_ce (i_status_ce),
    .i_control_ce(i_control_ce),
    .i_wr        (i_wr),
    .i_rd        (i_rd),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .i_rx        (i_rx),
    .o_tx        (o_tx),
    .o_irq       (o_irq)
  );

  typedef struct {
    logic [2:0] ce;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [2:0] ce, input logic wr, input logic rd, input logic [7:0] wd);
    {i_control_ce, i_status_ce, i_data_ce} = ce;
    i_wr    = wr;
    i_rd    = rd;
    i_wdata = wd;
    tick();
    {i_control_ce, i_status_ce, i_data_ce} = 3'b000;
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    i_wdata = 8'h00;
  endtask

  task automatic reg_read(input logic [2:0] ce, input logic [7:0] exp, input string name);
    bus(ce, 1'b0, 1'b1, 8'h00);
    check(name, o_rdata, exp);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (CPB) tick();
    end
    i_rx = stop_bit;
    repeat (CPB) tick();
    i_rx = 1'b1;
  endtask

  initial begin
    logic [7:0] tx_byte;
    logic       exp_bit;

    vecs[0]  = '{3'b010, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0};
    vecs[1]  = '{3'b010, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[2]  = '{3'b010, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0};
    vecs[3]  = '{3'b100, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0};
    vecs[4]  = '{3'b100, 1'b0, 1'b1, 8'h00, 8'h02, 1'b1};
    vecs[5]  = '{3'b110, 1'b0, 1'b1, 8'h00, 8'h02, 1'b1};
    vecs[6]  = '{3'b100, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0};
    vecs[7]  = '{3'b100, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0};
    vecs[8]  = '{3'b011, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0};
    vecs[9]  = '{3'b000, 1'b1, 1'b1, 8'h99, 8'h02, 1'b0};
    vecs[10] = '{3'b100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{3'b100, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{3'b010, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0};

    i_reset = 1'b1;
    {i_control_ce, i_status_ce, i_data_ce} = 3'b000;
    i_wr = 1'b0; i_rd = 1'b0; i_wdata = 8'h00; i_rx = 1'b1;
    repeat (3) tick();
    check("reset_tx", {7'b0, o_tx}, 8'h01);
    check("reset_rdata", o_rdata, 8'h00);
    check("reset_irq", {7'b0, o_irq}, 8'h00);
    i_reset = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 13; v++) begin
      bus(vecs[v].ce, vecs[v].wr, vecs[v].rd, vecs[v].wdata);
      if (vecs[v].rd) begin
        check($sformatf("vec%0d_rdata", v), o_rdata, vecs[v].exp_rdata);
        check($sformatf("vec%0d_irq", v), {7'b0, o_irq}, {7'b0, vecs[v].exp_irq});
      end
    end

    // TX frame 0x55: sample i is taken after the edge one past the write + i
    tx_byte = 8'h55;
    bus(3'b001, 1'b1, 1'b0, tx_byte);
    check("tx_idle_before_start", {7'b0, o_tx}, 8'h01);
    for (int i = 0; i < 82; i++) begin
      if (i == 1) begin
        i_status_ce = 1'b1;
        i_rd        = 1'b1;
      end
      tick();
      i_status_ce = 1'b0;
      i_rd        = 1'b0;
      if (i == 1) check("tx_status_busy", o_rdata, 8'h12);
      if (i < 8)       exp_bit = 1'b0;
      else if (i < 72) exp_bit = tx_byte[(i - 8) / 8];
      else             exp_bit = 1'b1;
      check($sformatf("tx_line_%0d", i), {7'b0, o_tx}, {7'b0, exp_bit});
    end
    reg_read(3'b010, 8'h02, "tx_done_status");

    rx_frame(8'hA3, 1'b1);
    repeat (4) tick();
    reg_read(3'b010, 8'h03, "rx_a3_status");
    reg_read(3'b001, 8'hA3, "rx_a3_data");
    reg_read(3'b010, 8'h02, "rx_a3_status_after");

    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    repeat (4) tick();
    reg_read(3'b001, 8'h11, "overrun_data");
    reg_read(3'b010, 8'h06, "overrun_status");
    reg_read(3'b010, 8'h02, "overrun_cleared");

    rx_frame(8'h7E, 1'b0);
    repeat (4) tick();
    reg_read(3'b010, 8'h0B, "framing_status");
    reg_read(3'b001, 8'h7E, "framing_data");
    i_rx = 1'b0;
    repeat (2) tick();
    i_rx = 1'b1;
    repeat (20) tick();
    reg_read(3'b010, 8'h02, "glitch_status");

    bus(3'b100, 1'b1, 1'b0, 8'h01);
    rx_frame(8'h42, 1'b1);
    repeat (4) tick();
    check("irq_rx_set", {7'b0, o_irq}, 8'h01);
    reg_read(3'b001, 8'h42, "irq_data");
    repeat (2) tick();
    check("irq_rx_clear", {7'b0, o_irq}, 8'h00);
    bus(3'b100, 1'b1, 1'b0, 8'h00);

    bus(3'b001, 1'b1, 1'b0, 8'h0F);
    repeat (2) tick();
    check("midframe_start", {7'b0, o_tx}, 8'h00);
    i_reset = 1'b1;
    #1;
    check("midframe_reset_tx", {7'b0, o_tx}, 8'h01);
    check("midframe_reset_rdata", o_rdata, 8'h00);
    check("midframe_reset_irq", {7'b0, o_irq}, 8'h00);
    tick();
    i_reset = 1'b0;
    repeat (2) tick();
    reg_read(3'b010, 8'h02, "post_reset_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
